// File: rtl/route_arbiter_pkg.sv
// Shared definitions for the route arbiter: port-code width, local port index
// and the per-input state encoding.
package route_arbiter_pkg;

   localparam int PORT_W        = 4;
   localparam int PORTS_NUM_DEF = 4;
   localparam int LOCAL_PORT    = PORTS_NUM_DEF;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WAIT_PORT = 2'd1,
      ST_CONNECTED = 2'd2
   } in_state_e;

endpackage

// File: rtl/route_arbiter_rr.sv
// Round-robin arbiter: one-hot grant, search starts one past the last winner.
// The pointer only moves when enabled and at least one request is present.
module rr_arbiter #(
   parameter int N = 5
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic [N-1:0] req,
   output logic [N-1:0] grant
);

   localparam int PW = (N > 1) ? $clog2(N) : 1;

   logic [PW-1:0] ptr;
   logic [PW-1:0] ptr_nxt;

   always_comb begin
      logic [PW-1:0] idx;
      logic          found;
      grant   = '0;
      ptr_nxt = ptr;
      found   = 1'b0;
      idx     = '0;
      for (int i = 0; i < N; i++) begin
         idx = PW'((int'(ptr) + i) % N);
         if (!found && req[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            ptr_nxt    = (idx == PW'(N - 1)) ? '0 : idx + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr <= '0;
      end else if (en && (|req)) begin
         ptr <= ptr_nxt;
      end
   end

endmodule

// File: rtl/route_arbiter.sv
// Route arbiter: per-input FSM, one shared routing-table lookup per cycle, and a
// round-robin allocator per output port guarding exclusive ownership.
//
// state        | meaning
// ST_IDLE      | no route held; may be granted a lookup when req_valid is high
// ST_WAIT_PORT | lookup done, target latched; waiting for the target output
// ST_CONNECTED | owns target output until tail_release
module route_arbiter
   import route_arbiter_pkg::*;
#(
   parameter int NODES_NUM = 9,
   parameter int ADDR_SIZE = 4,
   parameter int PORTS_NUM = PORTS_NUM_DEF
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [PORTS_NUM:0]               req_valid,
   input  logic [(PORTS_NUM+1)*ADDR_SIZE-1:0] req_dest,
   output logic [PORTS_NUM:0]               req_ready,
   input  logic [PORTS_NUM:0]               tail_release,
   output logic [ADDR_SIZE-1:0]             rt_dest,
   input  logic [PORT_W-1:0]                rt_port,
   output logic [PORTS_NUM:0]               conn_valid,
   output logic [(PORTS_NUM+1)*PORT_W-1:0]  conn_port,
   output logic                             route_err
);

   localparam int N = PORTS_NUM + 1;

   if ((1 << ADDR_SIZE) < NODES_NUM) begin : g_addr_chk
      $error("ADDR_SIZE too narrow to address NODES_NUM nodes");
   end

   in_state_e         state     [N];
   in_state_e         state_nxt [N];
   logic [PORT_W-1:0] target     [N];
   logic [PORT_W-1:0] target_nxt [N];
   logic [N-1:0]      busy, busy_nxt;
   logic              route_err_nxt;
   logic [N-1:0]      lk_req, lk_gnt;
   logic [N-1:0][N-1:0] al_gnt;

   // Lookup requests are masked during reset so req_ready/rt_dest stay low.
   always_comb begin
      lk_req = '0;
      for (int k = 0; k < N; k++) begin
         lk_req[k] = req_valid[k] && (state[k] == ST_IDLE) && !rst;
      end
   end

   rr_arbiter #(.N(N)) u_lookup_arb (
      .clk   (clk),
      .rst   (rst),
      .en    (1'b1),
      .req   (lk_req),
      .grant (lk_gnt)
   );

   for (genvar o = 0; o < N; o++) begin : g_alloc
      logic [N-1:0] a_req;

      // Registered busy means an output freed at an edge is only seen free next cycle.
      always_comb begin
         a_req = '0;
         for (int k = 0; k < N; k++) begin
            a_req[k] = (state[k] == ST_WAIT_PORT) && (target[k] == PORT_W'(o)) && !busy[o];
         end
      end

      rr_arbiter #(.N(N)) u_out_arb (
         .clk   (clk),
         .rst   (rst),
         .en    (!busy[o]),
         .req   (a_req),
         .grant (al_gnt[o])
      );
   end

   always_comb begin
      rt_dest = '0;
      for (int k = 0; k < N; k++) begin
         if (lk_gnt[k]) begin
            rt_dest = req_dest[k*ADDR_SIZE +: ADDR_SIZE];
         end
      end
   end

   assign req_ready = lk_gnt;

   always_comb begin
      state_nxt     = state;
      target_nxt    = target;
      busy_nxt      = busy;
      route_err_nxt = 1'b0;
      for (int k = 0; k < N; k++) begin
         case (state[k])
            ST_IDLE: begin
               if (lk_gnt[k]) begin
                  if (rt_port > PORT_W'(PORTS_NUM)) begin
                     route_err_nxt = 1'b1;
                  end else begin
                     state_nxt[k]  = ST_WAIT_PORT;
                     target_nxt[k] = rt_port;
                  end
               end
            end
            ST_WAIT_PORT: begin
               for (int o = 0; o < N; o++) begin
                  if (al_gnt[o][k]) begin
                     state_nxt[k] = ST_CONNECTED;
                     busy_nxt[o]  = 1'b1;
                  end
               end
            end
            ST_CONNECTED: begin
               if (tail_release[k]) begin
                  state_nxt[k] = ST_IDLE;
                  for (int o = 0; o < N; o++) begin
                     if (target[k] == PORT_W'(o)) begin
                        busy_nxt[o] = 1'b0;
                     end
                  end
               end
            end
            default: state_nxt[k] = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < N; k++) begin
            state[k]  <= ST_IDLE;
            target[k] <= '0;
         end
         busy      <= '0;
         route_err <= 1'b0;
      end else begin
         for (int k = 0; k < N; k++) begin
            state[k]  <= state_nxt[k];
            target[k] <= target_nxt[k];
         end
         busy      <= busy_nxt;
         route_err <= route_err_nxt;
      end
   end

   always_comb begin
      conn_valid = '0;
      conn_port  = '0;
      for (int k = 0; k < N; k++) begin
         if (state[k] == ST_CONNECTED) begin
            conn_valid[k]                = 1'b1;
            conn_port[k*PORT_W +: PORT_W] = target[k];
         end
      end
   end

endmodule

// File: tb/tb_route_arbiter.sv
// Directed bench for route_arbiter with a small combinational routing table.
module tb_route_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [4:0]  req_valid = '0;
   logic [19:0] req_dest = '0;
   logic [4:0]  req_ready;
   logic [4:0]  tail_release = '0;
   logic [3:0]  rt_dest;
   logic [3:0]  rt_port;
   logic [4:0]  conn_valid;
   logic [19:0] conn_port;
   logic        route_err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   route_arbiter dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_dest     (req_dest),
      .req_ready    (req_ready),
      .tail_release (tail_release),
      .rt_dest      (rt_dest),
      .rt_port      (rt_port),
      .conn_valid   (conn_valid),
      .conn_port    (conn_port),
      .route_err    (route_err)
   );

   function automatic logic [3:0] table_port(input logic [3:0] d);
      case (d)
         4'd8:    return 4'd1;
         4'd2:    return 4'd2;
         4'd7:    return 4'hF;
         4'd1:    return 4'd3;
         default: return 4'd0;
      endcase
   endfunction

   always_comb rt_port = table_port(rt_dest);

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic set_dest(input int k, input logic [3:0] d);
      req_dest[k*4 +: 4] = d;
   endtask

   task automatic do_reset();
      next_cycle();
      rst = 1'b1;
      req_valid = '0;
      tail_release = '0;
      req_dest = '0;
      next_cycle();
      rst = 1'b0;
   endtask

   int order [6];
   int n_conn;
   logic [4:0] prev_cv;

   initial begin
      // reset state
      @(negedge clk);
      chk("rst_ready", req_ready, 0);
      chk("rst_conn_valid", conn_valid, 0);
      chk("rst_conn_port", conn_port, 0);
      chk("rst_route_err", route_err, 0);
      chk("rst_rt_dest", rt_dest, 0);

      // single request, first cycle after reset release
      next_cycle();
      rst = 1'b0;
      req_valid = 5'b00001;
      set_dest(0, 4'd8);
      @(negedge clk);
      chk("t1_ready", req_ready, 5'b00001);
      chk("t1_rt_dest", rt_dest, 4'd8);
      next_cycle();
      req_valid = '0;
      @(negedge clk);
      chk("t1_cv_c2", conn_valid, 0);
      next_cycle();
      @(negedge clk);
      chk("t1_cv_c3", conn_valid, 5'b00001);
      chk("t1_port_c3", conn_port, 20'h00001);
      next_cycle();
      tail_release = 5'b00001;
      next_cycle();
      tail_release = '0;
      @(negedge clk);
      chk("t1_released", conn_valid, 0);

      // three simultaneous requests from reset pointer
      do_reset();
      next_cycle();
      req_valid = 5'b01101;
      set_dest(0, 4'd8);
      set_dest(2, 4'd2);
      set_dest(3, 4'd1);
      @(negedge clk);
      chk("t2_ready_a", req_ready, 5'b00001);
      next_cycle();
      @(negedge clk);
      chk("t2_ready_b", req_ready, 5'b00100);
      next_cycle();
      @(negedge clk);
      chk("t2_ready_c", req_ready, 5'b01000);
      next_cycle();
      @(negedge clk);
      chk("t2_no_regrant", req_ready, 0);
      next_cycle();
      @(negedge clk);
      chk("t2_cv", conn_valid, 5'b01101);
      chk("t2_port", conn_port, 20'h03201);
      chk("t2_no_regrant2", req_ready, 0);
      next_cycle();
      tail_release = 5'b01101;
      req_valid = '0;
      next_cycle();
      tail_release = '0;
      @(negedge clk);
      chk("t2_released", conn_valid, 0);

      // contention on output 2; release on a waiting input is ignored
      next_cycle();
      req_valid = 5'b01010;
      set_dest(1, 4'd2);
      set_dest(3, 4'd2);
      @(negedge clk);
      chk("t3_ready_a", req_ready, 5'b00010);
      next_cycle();
      @(negedge clk);
      chk("t3_ready_b", req_ready, 5'b01000);
      next_cycle();
      req_valid = '0;
      @(negedge clk);
      chk("t3_cv_first", conn_valid, 5'b00010);
      chk("t3_port_first", conn_port, 20'h00020);
      next_cycle();
      tail_release = 5'b01010;
      @(negedge clk);
      chk("t3_cv_wait", conn_valid, 5'b00010);
      next_cycle();
      tail_release = '0;
      @(negedge clk);
      chk("t3_cv_r1", conn_valid, 0);
      next_cycle();
      @(negedge clk);
      chk("t3_cv_r2", conn_valid, 5'b01000);
      chk("t3_port_r2", conn_port, 20'h02000);
      next_cycle();
      tail_release = 5'b01000;
      next_cycle();
      tail_release = '0;
      @(negedge clk);
      chk("t3_released", conn_valid, 0);

      // invalid lookup result
      next_cycle();
      req_valid = 5'b10000;
      set_dest(4, 4'd7);
      @(negedge clk);
      chk("t4_ready", req_ready, 5'b10000);
      chk("t4_rt_dest", rt_dest, 4'd7);
      chk("t4_err_c0", route_err, 0);
      next_cycle();
      req_valid = '0;
      @(negedge clk);
      chk("t4_err_c1", route_err, 1);
      chk("t4_cv_c1", conn_valid, 0);
      next_cycle();
      @(negedge clk);
      chk("t4_err_c2", route_err, 0);
      chk("t4_cv_c2", conn_valid, 0);

      // reset while connected
      next_cycle();
      req_valid = 5'b00011;
      set_dest(0, 4'd8);
      set_dest(1, 4'd1);
      @(negedge clk);
      chk("t5_ready_a", req_ready, 5'b00001);
      next_cycle();
      @(negedge clk);
      chk("t5_ready_b", req_ready, 5'b00010);
      next_cycle();
      req_valid = '0;
      next_cycle();
      @(negedge clk);
      chk("t5_cv", conn_valid, 5'b00011);
      chk("t5_port", conn_port, 20'h00031);
      next_cycle();
      rst = 1'b1;
      req_valid = 5'b00100;
      set_dest(2, 4'd2);
      #1;
      chk("t5_rst_cv", conn_valid, 0);
      chk("t5_rst_port", conn_port, 0);
      chk("t5_rst_ready", req_ready, 0);
      chk("t5_rst_rt_dest", rt_dest, 0);
      next_cycle();
      rst = 1'b0;
      @(negedge clk);
      chk("t5_post_ready", req_ready, 5'b00100);
      chk("t5_post_rt_dest", rt_dest, 4'd2);
      next_cycle();
      req_valid = '0;
      next_cycle();
      @(negedge clk);
      chk("t5_post_cv", conn_valid, 5'b00100);
      chk("t5_post_port", conn_port, 20'h00200);
      next_cycle();
      tail_release = 5'b00100;
      next_cycle();
      tail_release = '0;

      // all inputs hammer output 2, each connection released at once
      do_reset();
      for (int k = 0; k < 5; k++) set_dest(k, 4'd2);
      for (int i = 0; i < 6; i++) order[i] = 15;
      n_conn = 0;
      prev_cv = '0;
      next_cycle();
      req_valid = 5'b11111;
      for (int c = 0; c < 30; c++) begin
         next_cycle();
         tail_release = conn_valid;
         @(negedge clk);
         chk("t6_onehot", {31'd0, $onehot0(conn_valid)}, 1);
         if (conn_valid != 0 && prev_cv == 0 && n_conn < 6) begin
            for (int k = 0; k < 5; k++) begin
               if (conn_valid[k]) order[n_conn] = k;
            end
            n_conn++;
         end
         prev_cv = conn_valid;
      end
      req_valid = '0;
      tail_release = '0;
      chk("t6_order0", order[0], 0);
      chk("t6_order1", order[1], 1);
      chk("t6_order2", order[2], 2);
      chk("t6_order3", order[3], 3);
      chk("t6_order4", order[4], 4);
      chk("t6_order5", order[5], 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
